// File: rtl/skew_feed_ctrl.sv
// Feeds feature-buffer vectors into a downstream skew register file, then
// flushes the skew pipeline with DRAIN_CYCLES all-zero vectors before signalling done.
module skew_feed_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_COUNT = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int DRAIN_CYCLES = 42
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH:0]                num_vec,
  output logic                               mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              mem_rd_addr,
  input  logic [BUFFER_COUNT*DATA_WIDTH-1:0] mem_rd_data,
  output logic                               read_en,
  output logic [BUFFER_COUNT*DATA_WIDTH-1:0] data_out,
  output logic                               busy,
  output logic                               done
);

  localparam int NW = ADDR_WIDTH + 1;
  localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [NW-1:0]   rem_r;        // reads still to issue after the current one
  logic            rd_valid_r;   // mem_rd_data is valid this cycle
  logic [CW-1:0]   drain_cnt_r;

  assign busy = (state_r != IDLE);

  // Transfer sequencer: read issue, data capture, zero flush and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rem_r       <= '0;
      rd_valid_r  <= 1'b0;
      drain_cnt_r <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      read_en     <= 1'b0;
      data_out    <= '0;
      done        <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      rd_valid_r <= 1'b0;
      read_en    <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (num_vec != '0) begin
              state_r     <= FETCH;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= base_addr;
              rem_r       <= num_vec - NW'(1'b1);
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: begin
          rd_valid_r <= mem_rd_en;
          if (rd_valid_r) begin
            read_en  <= 1'b1;
            data_out <= mem_rd_data;
          end else begin
            data_out <= '0;
          end
          if (rem_r != '0) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= mem_rd_addr + ADDR_WIDTH'(1'b1);
            rem_r       <= rem_r - NW'(1'b1);
          end else begin
            mem_rd_en <= 1'b0;
          end
          // Last vector is on data_out now and nothing is in flight behind it.
          if (!mem_rd_en && !rd_valid_r && read_en) begin
            if (DRAIN_CYCLES > 0) begin
              state_r     <= DRAIN;
              read_en     <= 1'b1;
              drain_cnt_r <= CW'(1'b1);
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end else begin
            state_r <= FETCH;
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r     <= DONE;
            done        <= 1'b1;
            drain_cnt_r <= '0;
          end else begin
            read_en     <= 1'b1;
            drain_cnt_r <= drain_cnt_r + CW'(1'b1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/skew_feed_ctrl.md
SKEW_FEED_CTRL -- requirements
Module: skew_feed_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, lane width in bits.
REQ-002 SHALL have parameter BUFFER_COUNT, default 16, lanes per vector.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, feature-buffer address width.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 42, zero-flush cycles after the last vector.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  request one transfer; sampled only when busy=0.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  first vector address, captured with start.
REQ-009 SHALL have port num_vec  input  ADDR_WIDTH+1  vector count N, captured with start.
REQ-010 SHALL have port mem_rd_en  output  1  feature-buffer read strobe.
REQ-011 SHALL have port mem_rd_addr  output  ADDR_WIDTH  feature-buffer read address.
REQ-012 SHALL have port mem_rd_data  input  BUFFER_COUNT*DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
REQ-013 SHALL have port read_en  output  1  shift enable to the downstream skew register file.
REQ-014 SHALL have port data_out  output  BUFFER_COUNT*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-018 IDLE with start=1 and N>0 SHALL capture base_addr/num_vec and go to FETCH; with N=0 SHALL go directly to DONE.
REQ-019 start SHALL be ignored in FETCH, DRAIN and DONE; captured parameters SHALL NOT change mid-transfer.
REQ-020 Cycle C1 = first cycle after start acceptance; mem_rd_en SHALL be high in C1..CN with mem_rd_addr = base_addr+k in cycle C(k+1), k=0..N-1.
REQ-021 Address increment SHALL wrap modulo 2^ADDR_WIDTH.
REQ-022 mem_rd_data returned in cycle C(k+2) SHALL be registered and presented on data_out with read_en=1 in cycle C(k+3).
REQ-023 read_en SHALL be continuously high from C3 through C(N+2+DRAIN_CYCLES) with no gaps.
REQ-024 In C(N+3)..C(N+2+DRAIN_CYCLES) (DRAIN), data_out SHALL be all zeros with read_en=1.
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles, counted by an internal counter; DRAIN_CYCLES=0 SHALL skip DRAIN.
REQ-026 done SHALL be high for exactly one cycle, C(N+3+DRAIN_CYCLES) for N>0 or C1 for N=0, with read_en=0 and data_out=0 in that cycle.
REQ-027 DONE SHALL return to IDLE unconditionally; a start coincident with done SHALL be ignored.
REQ-028 Outside the windows of REQ-020, REQ-023 and REQ-026, mem_rd_en, read_en and done SHALL be 0, and data_out SHALL be 0.
REQ-029 mem_rd_en, mem_rd_addr, read_en, data_out and done SHALL be driven from registers.
REQ-030 mem_rd_data SHALL be ignored in any cycle not following a mem_rd_en.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, with mem_rd_en=0, mem_rd_addr=0, read_en=0, data_out=0, busy=0, done=0, and all counters cleared.
REQ-032 Reset mid-transfer SHALL discard in-flight reads; no done pulse SHALL follow; the first start after release SHALL behave as from power-up.

Verification
REQ-033 N=4, base=0x010: mem_rd_en C1-C4 at 0x010-0x013; read_en+data C3-C6 matching memory; zeros C7-C48; done only in C49; busy C1-C49.
REQ-034 N=0: done in C1; mem_rd_en and read_en never asserted; busy high only in C1.
REQ-035 base=0x3FE, N=4: addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-036 start pulsed in C2 and in the done cycle with different base: ignored, no change; a start in the cycle after done is accepted.
REQ-037 rst_n low in C5 of the N=4 run: all outputs 0 at once; no done; a new start with N=1 gives read_en C3, drain C4-C45, done C46.
REQ-038 N=1024 (full range): 1024 contiguous read_en data cycles followed by 42 drain cycles; no gaps, no extra pulses.
